microram_burst_ctrl: RTL and testbench

Burst initiator that drives the single-port 512x8 synchronous RAM port (address, write data, write enable, read data). It accepts one command at a time (address, length, direction) over a valid/ready handshake. Write bursts stream in on a write channel; read bursts stream out on a back-pressurable read channel. It sits between the project datapath/UART loader and the RAM wrapper, and is the only agent driving the RAM.

---
 rtl/microram_pkg.sv | 15 +
 rtl/microram_rd_skid.sv | 46 ++++
 rtl/microram_burst_ctrl.sv | 129 ++++++++++++
 tb/tb_microram_burst_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microram_pkg.sv
// Shared widths and controller state encoding for the microram burst path.
`default_nettype none
package microram_pkg;
  localparam int AW       = 9;
  localparam int DW       = 8;
  localparam int RD_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/microram_rd_skid.sv
// Small read-return FIFO; absorbs RAM data already in flight while the consumer stalls.
`default_nettype none
module microram_rd_skid #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule
`default_nettype wire

// File: rtl/microram_burst_ctrl.sv
// Burst initiator for the 512x8 synchronous RAM: one command at a time, streamed write
// channel in, back-pressurable read channel out.
`default_nettype none
module microram_burst_ctrl
  import microram_pkg::*;
#(
  parameter int AW       = microram_pkg::AW,
  parameter int DW       = microram_pkg::DW,
  parameter int RD_DEPTH = microram_pkg::RD_DEPTH
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);
  localparam int CW = $clog2(RD_DEPTH + 1);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] pointer;
  logic [AW-1:0] remaining;
  logic [AW-1:0] addr_hold;
  logic          inflight;
  logic          done_q;
  logic [CW-1:0] count;
  logic          empty;
  logic          pop;
  logic          issue;
  logic          we;
  logic          drain_exit;
  logic [CW:0]   occupancy;

  assign pop       = rd_valid & rd_ready;
  // Entries that will be held after this edge; one more read may be issued below the limit.
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    we         = 1'b0;
    issue      = 1'b0;
    drain_exit = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        wr_ready = 1'b1;
        we       = wr_valid;
        if (wr_valid && remaining == '0) state_next = IDLE;
      end
      READ: begin
        issue = (occupancy < (CW + 1)'(RD_DEPTH));
        if (issue && remaining == '0) state_next = DRAIN;
      end
      DRAIN: begin
        // A pending push is exactly an in-flight read, so inflight covers both.
        if (empty && !inflight) begin
          drain_exit = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pointer   <= '0;
      remaining <= '0;
      addr_hold <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      inflight  <= issue;
      done_q    <= (we && remaining == '0) || drain_exit;
      addr_hold <= ram_addr;
      if (state == IDLE && cmd_valid) begin
        pointer   <= cmd_addr;
        remaining <= cmd_len;
      end else if (we || issue) begin
        pointer   <= pointer + AW'(1);
        remaining <= remaining - AW'(1);
      end
    end
  end

  assign ram_we   = we;
  assign ram_addr = (we || issue) ? pointer : addr_hold;
  assign ram_din  = (state == WRITE) ? wr_data : '0;
  assign done     = done_q;
  assign rd_valid = ~empty;

  microram_rd_skid #(
    .DW    (DW),
    .DEPTH (RD_DEPTH)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (ram_dout),
    .pop       (pop),
    .head      (rd_data),
    .count     (count),
    .empty     (empty)
  );
endmodule
`default_nettype wire

// File: tb/tb_microram_burst_ctrl.sv
// Self-checking bench: behavioural RAM plus an expected-memory model of burst effects.
`timescale 1ns/1ps
`default_nettype none
module tb_microram_burst_ctrl;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [8:0] cmd_addr = '0, cmd_len = '0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       done;
  logic [8:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       ram_we;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram_mem [512];
  logic [7:0] exp_mem [512];

  logic [7:0] wdata_q[$];
  logic [8:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  int         we_win_q[$];
  logic [7:0] rd_q[$];
  int         rd_win_q[$];
  int         done_cnt, done_win, first_valid_win, stall_err;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  microram_burst_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_cmd(input bit wr, input logic [8:0] a, input logic [8:0] l, output bit ok);
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic fill_wdata(input int n);
    wdata_q.delete();
    for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom));
  endtask

  task automatic model_write(input logic [8:0] a, input int n);
    for (int i = 0; i < n; i++) exp_mem[9'(a + 9'(i))] = wdata_q[i];
  endtask

  task automatic run_write(input logic [8:0] a, input logic [8:0] l, input bit gaps, output bit timeout);
    bit ok;
    int idx, after;
    idx = 0; after = 0; timeout = 1'b0;
    we_addr_q.delete(); we_data_q.delete(); we_win_q.delete();
    done_cnt = 0; done_win = -1;
    issue_cmd(1'b1, a, l, ok);
    if (!ok) begin timeout = 1'b1; return; end
    for (int j = 0; j < 3000 && after < 3; j++) begin
      wr_valid = (idx <= int'(l)) && (!gaps || $urandom_range(0, 2) != 0);
      wr_data  = (idx <= int'(l)) ? wdata_q[idx] : 8'h00;
      #1;
      if (ram_we) begin
        we_addr_q.push_back(ram_addr); we_data_q.push_back(ram_din); we_win_q.push_back(j);
      end
      if (wr_valid && wr_ready) idx++;
      if (done) begin done_cnt++; if (done_win < 0) done_win = j; end
      if (done_cnt > 0) after++;
      tick();
    end
    wr_valid = 1'b0;
    if (done_cnt == 0) timeout = 1'b1;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic run_read(input logic [8:0] a, input logic [8:0] l, input int mode,
                          input int abort_after, output bit timeout);
    bit ok, prev_stall;
    logic [7:0] prev_data;
    int after;
    after = 0; timeout = 1'b0; prev_stall = 1'b0; prev_data = '0;
    rd_q.delete(); rd_win_q.delete();
    done_cnt = 0; done_win = -1; first_valid_win = -1; stall_err = 0;
    issue_cmd(1'b0, a, l, ok);
    if (!ok) begin timeout = 1'b1; return; end
    for (int j = 0; j < 3000 && after < 3; j++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (j % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (prev_stall && (!rd_valid || rd_data !== prev_data)) stall_err++;
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (rd_valid && first_valid_win < 0) first_valid_win = j;
      if (rd_valid && rd_ready) begin rd_q.push_back(rd_data); rd_win_q.push_back(j); end
      if (done) begin done_cnt++; if (done_win < 0) done_win = j; end
      if (done_cnt > 0) after++;
      tick();
      if (abort_after > 0 && rd_q.size() >= abort_after) break;
    end
    rd_ready = 1'b0;
    if (done_cnt == 0 && abort_after == 0) timeout = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_checks++; if (ram_addr !== 9'h000) begin n_fail++; $display("FAIL reset_ram_addr: got %h want 000", ram_addr); end
    n_checks++; if (ram_din !== 8'h00) begin n_fail++; $display("FAIL reset_ram_din: got %h want 00", ram_din); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_wrap();
    bit to;
    wdata_q.delete();
    for (int i = 0; i < 4; i++) wdata_q.push_back(8'hA0 + 8'(i));
    run_write(9'h1FE, 9'd3, 1'b0, to);
    model_write(9'h1FE, 4);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wrap_timeout: got %b want 0", to); end
    n_checks++; if (we_addr_q.size() !== 4) begin n_fail++; $display("FAIL wrap_we_count: got %0d want 4", we_addr_q.size()); end
    for (int i = 0; i < 4 && i < we_addr_q.size(); i++) begin
      n_checks++;
      if (we_addr_q[i] !== 9'(9'h1FE + 9'(i)) || we_data_q[i] !== wdata_q[i] || we_win_q[i] !== i) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: got addr %h data %h cycle %0d want addr %h data %h cycle %0d",
                 i, we_addr_q[i], we_data_q[i], we_win_q[i], 9'(9'h1FE + 9'(i)), wdata_q[i], i);
      end
    end
    n_checks++; if (done_cnt !== 1 || done_win !== 4) begin n_fail++; $display("FAIL wrap_done: got %0d pulses at %0d want 1 at 4", done_cnt, done_win); end
  endtask

  task automatic test_read_back();
    bit to;
    run_read(9'h1FE, 9'd3, 0, 0, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rdback_timeout: got %b want 0", to); end
    n_checks++; if (rd_q.size() !== 4) begin n_fail++; $display("FAIL rdback_count: got %0d want 4", rd_q.size()); end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      n_checks++;
      if (rd_q[i] !== 8'hA0 + 8'(i) || rd_win_q[i] !== 2 + i) begin
        n_fail++;
        $display("FAIL rdback_beat%0d: got %h at cycle %0d want %h at cycle %0d", i, rd_q[i], rd_win_q[i], 8'hA0 + 8'(i), 2 + i);
      end
    end
    n_checks++; if (first_valid_win !== 2) begin n_fail++; $display("FAIL rdback_latency: got %0d want 2", first_valid_win); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rdback_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_read_stall();
    bit to;
    logic [8:0] a;
    for (int mode = 1; mode <= 2; mode++) begin
      a = 9'($urandom);
      fill_wdata(8);
      run_write(a, 9'd7, 1'b1, to);
      model_write(a, 8);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_wr_timeout: got %b want 0", to); end
      run_read(a, 9'd7, mode, 0, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_rd_timeout: got %b want 0", to); end
      n_checks++; if (rd_q.size() !== 8) begin n_fail++; $display("FAIL stall_count m%0d: got %0d want 8", mode, rd_q.size()); end
      for (int i = 0; i < rd_q.size() && i < 8; i++) begin
        n_checks++;
        if (rd_q[i] !== exp_mem[9'(a + 9'(i))]) begin
          n_fail++; $display("FAIL stall_data m%0d b%0d: got %h want %h", mode, i, rd_q[i], exp_mem[9'(a + 9'(i))]);
        end
      end
      n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL stall_stable m%0d: got %0d changes want 0", mode, stall_err); end
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL stall_done m%0d: got %0d want 1", mode, done_cnt); end
    end
  endtask

  task automatic test_single();
    bit to;
    fill_wdata(1);
    run_write(9'h0AA, 9'd0, 1'b0, to);
    model_write(9'h0AA, 1);
    n_checks++; if (we_addr_q.size() !== 1) begin n_fail++; $display("FAIL single_we_count: got %0d want 1", we_addr_q.size()); end
    n_checks++; if (we_addr_q.size() > 0 && we_addr_q[0] !== 9'h0AA) begin n_fail++; $display("FAIL single_we_addr: got %h want 0aa", we_addr_q[0]); end
    n_checks++; if (done_cnt !== 1 || to) begin n_fail++; $display("FAIL single_wr_done: got %0d want 1", done_cnt); end
    run_read(9'h0AA, 9'd0, 0, 0, to);
    n_checks++; if (rd_q.size() !== 1) begin n_fail++; $display("FAIL single_rd_count: got %0d want 1", rd_q.size()); end
    n_checks++; if (rd_q.size() > 0 && rd_q[0] !== exp_mem[9'h0AA]) begin n_fail++; $display("FAIL single_rd_data: got %h want %h", rd_q[0], exp_mem[9'h0AA]); end
    n_checks++; if (done_cnt !== 1 || to) begin n_fail++; $display("FAIL single_rd_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_cmd_hold();
    bit acc, second_acc, seen_done;
    int idx, busy_err, ndone;
    acc = 1'b0; second_acc = 1'b0; seen_done = 1'b0; idx = 0; busy_err = 0; ndone = 0;
    fill_wdata(4);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h100; cmd_len = 9'd3;
    for (int i = 0; i < 50 && !acc; i++) begin #1; acc = cmd_ready; tick(); end
    cmd_write = 1'b0;
    for (int j = 0; j < 200 && !seen_done; j++) begin
      wr_valid = (idx <= 3);
      wr_data  = (idx <= 3) ? wdata_q[idx] : 8'h00;
      #1;
      if (wr_valid && wr_ready) idx++;
      if (done) begin seen_done = 1'b1; second_acc = cmd_ready; end
      else if (cmd_ready) busy_err++;
      tick();
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;
    model_write(9'h100, 4);
    n_checks++; if (busy_err !== 0) begin n_fail++; $display("FAIL hold_busy_ready: got %0d cycles want 0", busy_err); end
    n_checks++; if (second_acc !== 1'b1) begin n_fail++; $display("FAIL hold_accept_in_done: got %b want 1", second_acc); end
    rd_q.delete();
    for (int j = 0; j < 200 && ndone == 0; j++) begin
      rd_ready = 1'b1;
      #1;
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
      if (done) ndone++;
      tick();
    end
    rd_ready = 1'b0;
    n_checks++; if (ndone !== 1 || rd_q.size() !== 4) begin n_fail++; $display("FAIL hold_second_read: got %0d beats %0d done want 4 beats 1 done", rd_q.size(), ndone); end
    for (int i = 0; i < rd_q.size() && i < 4; i++) begin
      n_checks++;
      if (rd_q[i] !== wdata_q[i]) begin n_fail++; $display("FAIL hold_data b%0d: got %h want %h", i, rd_q[i], wdata_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int bad;
    logic [8:0] a;
    a = 9'($urandom);
    fill_wdata(8);
    run_write(a, 9'd7, 1'b0, to);
    model_write(a, 8);
    run_read(a, 9'd7, 0, 3, to);
    n_checks++; if (rd_q.size() !== 3) begin n_fail++; $display("FAIL rstmid_partial: got %0d beats want 3", rd_q.size()); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_valid: got %b want 0", rd_valid); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_cmd_ready: got %b want 1", cmd_ready); end
    tick();
    reset_n = 1'b1;
    bad = 0;
    for (int j = 0; j < 8; j++) begin
      #1;
      if (done || rd_valid || !cmd_ready) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d bad cycles want 0", bad); end
    run_read(a, 9'd7, 2, 0, to);
    n_checks++; if (rd_q.size() !== 8 || done_cnt !== 1 || to) begin n_fail++; $display("FAIL rstmid_reread: got %0d beats %0d done want 8 beats 1 done", rd_q.size(), done_cnt); end
    for (int i = 0; i < rd_q.size() && i < 8; i++) begin
      n_checks++;
      if (rd_q[i] !== exp_mem[9'(a + 9'(i))]) begin n_fail++; $display("FAIL rstmid_data b%0d: got %h want %h", i, rd_q[i], exp_mem[9'(a + 9'(i))]); end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [8:0] a, l;
    int errs;
    for (int it = 0; it < 6; it++) begin
      a = 9'($urandom);
      l = 9'($urandom_range(0, 15));
      fill_wdata(int'(l) + 1);
      run_write(a, l, 1'($urandom_range(0, 1)), to);
      model_write(a, int'(l) + 1);
      errs = 0;
      for (int i = 0; i < we_addr_q.size(); i++)
        if (we_addr_q[i] !== 9'(a + 9'(i)) || we_data_q[i] !== wdata_q[i]) errs++;
      n_checks++; if (to || we_addr_q.size() !== int'(l) + 1 || errs !== 0 || done_cnt !== 1) begin
        n_fail++; $display("FAIL rand_write%0d: got %0d writes %0d bad %0d done want %0d writes 0 bad 1 done", it, we_addr_q.size(), errs, done_cnt, int'(l) + 1);
      end
      a = a - 9'($urandom_range(0, 3));
      l = l + 9'($urandom_range(0, 3));
      run_read(a, l, $urandom_range(0, 2), 0, to);
      errs = 0;
      for (int i = 0; i < rd_q.size(); i++)
        if (rd_q[i] !== exp_mem[9'(a + 9'(i))]) errs++;
      n_checks++; if (to || rd_q.size() !== int'(l) + 1 || errs !== 0 || done_cnt !== 1 || stall_err !== 0) begin
        n_fail++; $display("FAIL rand_read%0d: got %0d beats %0d bad %0d done %0d unstable want %0d beats clean", it, rd_q.size(), errs, done_cnt, stall_err, int'(l) + 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 8'($urandom);
      exp_mem[i] = ram_mem[i];
    end
    tick();
    tick();
    test_reset();
    test_write_wrap();
    test_read_back();
    test_read_stall();
    test_single();
    test_cmd_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
